// File: rtl/iic_slave_eeprom_if.sv
// Status/debug bundle for the IIC slave EEPROM.
// The open-drain scl/sda pair stays on the module boundary because it is a
// resolved inout net; this interface carries the clk-domain outputs.
// Strobe semantics: wr_stb is a one-clk pulse that qualifies wr_data.
// There is no back-pressure: a consumer must take wr_data in the cycle
// wr_stb is high (wr_data then holds until the next commit).
interface iic_slave_eeprom_if;
  logic        busy;
  logic        wr_stb;
  logic [7:0]  wr_data;
  logic [3:0]  dbg_state;
  logic [15:0] dbg_ptr;

  modport slave (
    output busy, wr_stb, wr_data, dbg_state, dbg_ptr
  );

  modport master (
    input busy, wr_stb, wr_data, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/iic_slave_eeprom.sv
// IIC slave EEPROM: 7-bit device address, 16-bit address pointer of which the
// low MEM_AW bits index a 2^MEM_AW byte memory, sequential read/write with
// pointer wrap. scl/sda are oversampled by clk through 2-flop synchronizers.
// Optional feature macro IIC_SLV_WP_EN adds a write-protect input 'wp'.
module iic_slave_eeprom #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000,
  parameter int         MEM_AW   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
`ifdef IIC_SLV_WP_EN
  input  logic wp,
`endif
  iic_slave_eeprom_if.slave bus
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] DEV     = 4'd1;
  localparam logic [3:0] ACK_DEV = 4'd2;
  localparam logic [3:0] AHI     = 4'd3;
  localparam logic [3:0] ACK_AHI = 4'd4;
  localparam logic [3:0] ALO     = 4'd5;
  localparam logic [3:0] ACK_ALO = 4'd6;
  localparam logic [3:0] WR      = 4'd7;
  localparam logic [3:0] ACK_WR  = 4'd8;
  localparam logic [3:0] RD      = 4'd9;
  localparam logic [3:0] RD_ACK  = 4'd10;
  localparam logic [3:0] WAIT    = 4'd11;

  logic [1:0]  scl_q, sda_q;
  logic        scl_d, sda_d;
  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  sr;
  logic        rw;
  logic        sda_oe;
  logic        busy;
  logic        wr_stb;
  logic [7:0]  wr_data;
  logic [15:0] ptr;
  logic [15:0] ptr_inc;
  logic [7:0]  rx_byte;
  logic [7:0]  mem_rd;
  logic        mem_we;
  logic        wp_on;

  logic [7:0]  mem [0:(1<<MEM_AW)-1];

`ifdef IIC_SLV_WP_EN
  assign wp_on = wp;
`else
  assign wp_on = 1'b0;
`endif

  // Open drain: only ever pull low, otherwise float.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign bus.busy      = busy;
  assign bus.wr_stb    = wr_stb;
  assign bus.wr_data   = wr_data;
  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr;

  // Synchronize the bus lines and keep one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[0], scl};
      sda_q <= {sda_q[0], sda};
      scl_d <= scl_q[1];
      sda_d <= sda_q[1];
    end
  end

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // Byte being completed on this rising edge, and the next pointer value
  // (only the memory-index bits roll over).
  always_comb begin
    rx_byte = {sr[6:0], sda_s};
    ptr_inc = ptr;
    ptr_inc[MEM_AW-1:0] = ptr[MEM_AW-1:0] + MEM_AW'(1);
  end

  assign mem_rd = mem[ptr[MEM_AW-1:0]];
  assign mem_we = (state == WR) && scl_rise && (bit_cnt == 4'd7) &&
                  !start_det && !stop_det && !wp_on && !rst;

  // Memory array is not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr[MEM_AW-1:0]] <= rx_byte;
  end

  // Protocol FSM: START/STOP override everything, otherwise per-state
  // handling of the synchronized SCL edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      sr      <= 8'd0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_data <= 8'd0;
      ptr     <= 16'd0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state   <= DEV;
        bit_cnt <= 4'd0;
        sr      <= 8'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          DEV, AHI, ALO, WR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              sr      <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              // Data byte commits on its 8th rising edge.
              if (state == WR && bit_cnt == 4'd7) begin
                ptr <= ptr_inc;
                if (!wp_on) begin
                  wr_stb  <= 1'b1;
                  wr_data <= rx_byte;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              case (state)
                DEV: begin
                  if (sr[7:1] == DEV_ADDR) begin
                    state  <= ACK_DEV;
                    sda_oe <= 1'b1;
                    busy   <= 1'b1;
                    rw     <= sr[0];
                  end else begin
                    state <= WAIT;
                    busy  <= 1'b0;
                  end
                end
                AHI: begin
                  ptr[15:8] <= sr;
                  state     <= ACK_AHI;
                  sda_oe    <= 1'b1;
                end
                ALO: begin
                  ptr[7:0] <= sr;
                  state    <= ACK_ALO;
                  sda_oe   <= 1'b1;
                end
                default: begin
                  state  <= ACK_WR;
                  sda_oe <= ~wp_on;
                end
              endcase
            end
          end
          ACK_DEV, ACK_AHI, ACK_ALO, ACK_WR: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              sr      <= 8'd0;
              case (state)
                ACK_DEV: begin
                  if (rw) begin
                    // First read bit goes out on the edge ending the ACK.
                    state  <= RD;
                    sr     <= mem_rd;
                    sda_oe <= ~mem_rd[7];
                  end else begin
                    state <= AHI;
                  end
                end
                ACK_AHI: state <= ALO;
                default: state <= WR;
              endcase
            end
          end
          RD: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= RD_ACK;
              end else if (bit_cnt != 4'd0) begin
                sr     <= {sr[6:0], 1'b0};
                sda_oe <= ~sr[6];
              end
            end
          end
          RD_ACK: begin
            // bit_cnt==8 marks an ACK seen, waiting for the falling edge.
            if (scl_rise) begin
              if (sda_s) begin
                state <= WAIT;
              end else begin
                ptr     <= ptr_inc;
                bit_cnt <= 4'd8;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sr      <= mem_rd;
              sda_oe  <= ~mem_rd[7];
              bit_cnt <= 4'd0;
              state   <= RD;
            end
          end
          IDLE, WAIT: state <= state;
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/iic_slave_eeprom.md
IIC_SLAVE_EEPROM -- requirements
Module: iic_slave_eeprom

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b1010000, 7-bit target address matched against the first byte after START.
REQ-002 SHALL have parameter MEM_AW, default 8, memory address width; the memory holds 2^MEM_AW bytes.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port scl, input, 1, bus clock driven by the initiator.
REQ-006 SHALL have port sda, inout, 1, open-drain data line: drives 0 or high-Z, never 1.
REQ-007 SHALL have port busy, output, 1, high from an address-matched START until STOP or mismatch.
REQ-008 SHALL have port wr_stb, output, 1, one-clk pulse per byte committed to memory.
REQ-009 SHALL have port wr_data, output, 8, last byte committed, held until the next commit.

Function
REQ-010 SHALL pass scl and sda through 2-flop synchronizers and detect all edges/conditions on the synchronized copies; SCL_RISE and SCL_FALL are 1-clk pulses.
REQ-011 SHALL detect START as sda falling while scl high, and STOP as sda rising while scl high.
REQ-012 SHALL implement states IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WR, ACK_WR, RD, RD_ACK, WAIT.
REQ-013 SHALL go to DEV from any state on START (including repeated START), clearing bit counter and shift register.
REQ-014 SHALL go to IDLE and release sda from any state on STOP, and stay in IDLE otherwise.
REQ-015 SHALL sample sda on SCL_RISE, MSB first, 8 bits per byte.
REQ-016 SHALL drive ACK (sda=0) from the SCL_FALL after bit 8 until the SCL_FALL after the 9th clock, then release.
REQ-017 DEV: on address match SHALL ACK and go to AHI if R/W=0 or to RD if R/W=1; on mismatch SHALL not ACK and go to WAIT until START/STOP.
REQ-018 AHI/ALO SHALL ACK each byte and load a 16-bit address pointer; only the low MEM_AW bits index memory.
REQ-019 WR SHALL ACK each data byte, write it to mem[ptr] at the 8th SCL_RISE, pulse wr_stb that same clk, update wr_data and increment ptr.
REQ-020 RD SHALL present mem[ptr] on sda, each bit changed only on SCL_FALL (first bit on the SCL_FALL ending the ACK), releasing sda for '1' bits.
REQ-021 RD_ACK SHALL sample the initiator's 9th bit: 0 (ACK) increments ptr and sends the next byte; 1 (NACK) goes to WAIT.
REQ-022 SHALL increment ptr modulo 2^MEM_AW: 0xFF wraps to 0x00 with the default width, for both reads and writes.
REQ-023 SHALL retain ptr across STOP, so a read with R/W=1 and no address phase starts at the current pointer.
REQ-024 SHALL set busy on the SCL_FALL that begins ACK_DEV and clear it on STOP or entry to IDLE.
REQ-025 SHALL discard a partially received byte cut off by START/STOP: no write, no wr_stb.

Reset
REQ-026 SHALL, with rst high at a clk edge, enter IDLE, release sda, and set busy=0, wr_stb=0, wr_data=0, ptr=0, bit counter=0.
REQ-027 SHALL NOT clear memory contents on reset.
REQ-028 SHALL abandon a transaction interrupted by reset and release sda on the next clk edge.

Configuration
REQ-029 With IIC_SLV_WP_EN defined, SHALL add input port wp (1 bit); while wp=1, WR data bytes are NACKed, memory is not written, wr_stb stays 0, and ptr still increments.
REQ-030 Without IIC_SLV_WP_EN, port wp SHALL not exist and all writes behave as REQ-019.

Verification
REQ-031 Write: START,0xA0,0x00,0x0C,0x19,STOP -> four ACKs, one wr_stb, wr_data=0x19, mem[0x0C]=0x19.
REQ-032 Random read: START,0xA0,0x00,0x0C,Sr,0xA1, initiator NACK, STOP -> returns 0x19; sda released after the NACK.
REQ-033 Mismatch: START,0xA2 -> 9th bit reads 1, busy stays 0, following bytes ignored until STOP.
REQ-034 Wrap: write 0x11,0x22 starting at 0x00FF, then sequential read of 2 from 0x00FF -> mem[0xFF]=0x11, mem[0x00]=0x22, reads return 0x11,0x22.
REQ-035 Abort: STOP after 4 data bits of a write, then rst pulse mid-read -> no wr_stb, sda high-Z, state IDLE, ptr=0.
REQ-036 With IIC_SLV_WP_EN and wp=1: write 0x55 to 0x0010 -> data byte NACKed, mem[0x10] unchanged, wr_stb never asserted.
